// File: rtl/wb_arbiter_pkg.sv
// Shared constants for the writeback arbiter: data/address widths,
// source indices and the hard-wired zero register.
package wb_arbiter_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_AW     = 5;
    localparam int unsigned NUM_WB_SRC = 3;

    localparam int unsigned SRC_ALU = 0;
    localparam int unsigned SRC_LSU = 1;
    localparam int unsigned SRC_MDU = 2;

    localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/wb_arbiter_rr_arbiter3.sv
// Three-way round-robin arbiter. Owns the priority pointer; the grant is
// combinational from the valids and the pointer, and is suppressed in reset.
module rr_arbiter3
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned INIT_PTR = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_WB_SRC-1:0] valid,
    output logic [NUM_WB_SRC-1:0] grant_c,
    output logic [1:0]            grant_idx_c,
    output logic                  grant_any_c
);

    logic [1:0] ptr;

    // First valid source in the order ptr, ptr+1, ptr+2 wins; scanning from
    // the far end lets the nearest candidate overwrite the others.
    always_comb begin
        int unsigned cand;
        logic [1:0]  cand_idx;
        grant_c     = '0;
        grant_idx_c = ptr;
        grant_any_c = 1'b0;
        cand        = 0;
        cand_idx    = 2'd0;
        if (!rst) begin
            for (int unsigned k = 0; k < NUM_WB_SRC; k++) begin
                cand     = (32'(ptr) + NUM_WB_SRC - 1 - k) % NUM_WB_SRC;
                cand_idx = 2'(cand);
                if (valid[cand_idx]) begin
                    grant_c     = NUM_WB_SRC'(1) << cand_idx;
                    grant_idx_c = cand_idx;
                    grant_any_c = 1'b1;
                end
            end
        end
    end

    // Pointer moves just past the granted source; holds when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 2'(INIT_PTR);
        end else if (grant_any_c) begin
            ptr <= (grant_idx_c == 2'(NUM_WB_SRC - 1)) ? 2'd0 : grant_idx_c + 2'd1;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU/LSU/MDU results onto the single register
// bank write port, one registered write per cycle, round-robin priority.
// Optional macro WB_FWD_EN adds a forwarding compare on the write port.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned XLEN     = wb_arbiter_pkg::XLEN,
    parameter int unsigned REG_AW   = wb_arbiter_pkg::REG_AW,
    parameter int unsigned INIT_PTR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [REG_AW-1:0] lsu_rd,
    input  logic [XLEN-1:0]   lsu_data,
    input  logic              mdu_valid,
    output logic              mdu_ready,
    input  logic [REG_AW-1:0] mdu_rd,
    input  logic [XLEN-1:0]   mdu_data,
    output logic              REG_WR,
    output logic [REG_AW-1:0] DIR_WR,
    output logic [XLEN-1:0]   DI
`ifdef WB_FWD_EN
    ,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    output logic              fwd_a_hit,
    output logic              fwd_b_hit,
    output logic [XLEN-1:0]   fwd_data
`endif
);

    logic [NUM_WB_SRC-1:0] grant;
    logic [1:0]            grant_idx;
    logic                  grant_any;
    logic [REG_AW-1:0]     sel_rd;
    logic [XLEN-1:0]       sel_data;

    rr_arbiter3 #(
        .INIT_PTR (INIT_PTR)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .valid       ({mdu_valid, lsu_valid, alu_valid}),
        .grant_c     (grant),
        .grant_idx_c (grant_idx),
        .grant_any_c (grant_any)
    );

    assign alu_ready = grant[SRC_ALU];
    assign lsu_ready = grant[SRC_LSU];
    assign mdu_ready = grant[SRC_MDU];

    // Route the granted source's destination and data to the output stage.
    always_comb begin
        sel_rd   = alu_rd;
        sel_data = alu_data;
        case (grant_idx)
            2'(SRC_LSU): begin
                sel_rd   = lsu_rd;
                sel_data = lsu_data;
            end
            2'(SRC_MDU): begin
                sel_rd   = mdu_rd;
                sel_data = mdu_data;
            end
            default: begin
                sel_rd   = alu_rd;
                sel_data = alu_data;
            end
        endcase
    end

    // Output register; writes to x0 are accepted but never enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            REG_WR <= 1'b0;
            DIR_WR <= '0;
            DI     <= '0;
        end else if (grant_any) begin
            REG_WR <= (sel_rd != REG_AW'(ZERO_REG));
            DIR_WR <= sel_rd;
            DI     <= sel_data;
        end else begin
            REG_WR <= 1'b0;
        end
    end

`ifdef WB_FWD_EN
    // Bypass for the cycle a value sits on the write port before the bank has it.
    assign fwd_a_hit = REG_WR && (DIR_WR == rs1_addr);
    assign fwd_b_hit = REG_WR && (DIR_WR == rs2_addr);
    assign fwd_data  = DI;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized bench for wb_arbiter with a behavioural reference model and a
// few hand-computed directed checks.
module tb_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        alu_valid, lsu_valid, mdu_valid;
    logic        alu_ready, lsu_ready, mdu_ready;
    logic [4:0]  alu_rd, lsu_rd, mdu_rd;
    logic [31:0] alu_data, lsu_data, mdu_data;
    logic        REG_WR;
    logic [4:0]  DIR_WR;
    logic [31:0] DI;
`ifdef WB_FWD_EN
    logic [4:0]  rs1_addr, rs2_addr;
    logic        fwd_a_hit, fwd_b_hit;
    logic [31:0] fwd_data;
`endif

    wb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .mdu_valid (mdu_valid),
        .mdu_ready (mdu_ready),
        .mdu_rd    (mdu_rd),
        .mdu_data  (mdu_data),
        .REG_WR    (REG_WR),
        .DIR_WR    (DIR_WR),
        .DI        (DI)
`ifdef WB_FWD_EN
        ,
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .fwd_a_hit (fwd_a_hit),
        .fwd_b_hit (fwd_b_hit),
        .fwd_data  (fwd_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // producer state: requests held until accepted
    logic        v   [3];
    logic [4:0]  rd  [3];
    logic [31:0] dat [3];

    // reference model state
    int          m_ptr;
    logic        m_wr;
    logic [4:0]  m_dir;
    logic [31:0] m_di;
    bit          out_known;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // index of the source that must be granted, -1 if none
    function automatic int model_grant();
        if (rst) return -1;
        for (int k = 0; k < 3; k++) begin
            if (v[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
        end
        return -1;
    endfunction

    task automatic apply();
        alu_valid = v[0]; alu_rd = rd[0]; alu_data = dat[0];
        lsu_valid = v[1]; lsu_rd = rd[1]; lsu_data = dat[1];
        mdu_valid = v[2]; mdu_rd = rd[2]; mdu_data = dat[2];
    endtask

    // drive inputs, then compare all outputs against the model
    task automatic drive_and_check();
        int g;
        apply();
        #1;
        g = model_grant();
        chk("alu_ready", 32'(alu_ready), 32'(g == 0));
        chk("lsu_ready", 32'(lsu_ready), 32'(g == 1));
        chk("mdu_ready", 32'(mdu_ready), 32'(g == 2));
        if (out_known) begin
            chk("REG_WR", 32'(REG_WR), 32'(m_wr));
            chk("DIR_WR", 32'(DIR_WR), 32'(m_dir));
            chk("DI", DI, m_di);
`ifdef WB_FWD_EN
            chk("fwd_a_hit", 32'(fwd_a_hit), 32'(m_wr && (m_dir == rs1_addr)));
            chk("fwd_b_hit", 32'(fwd_b_hit), 32'(m_wr && (m_dir == rs2_addr)));
            chk("fwd_data", fwd_data, m_di);
`endif
        end
    endtask

    // advance one clock: update model and retire accepted requests
    task automatic tick();
        int g;
        g = model_grant();
        @(posedge clk);
        if (rst) begin
            m_wr = 1'b0; m_dir = '0; m_di = '0; m_ptr = 0;
        end else if (g >= 0) begin
            m_wr  = (rd[g] != 5'd0);
            m_dir = rd[g];
            m_di  = dat[g];
            m_ptr = (g + 1) % 3;
            v[g]  = 1'b0;
        end else begin
            m_wr = 1'b0;
        end
        out_known = 1'b1;
        @(negedge clk);
    endtask

    task automatic set_src(input int i, input logic [4:0] r, input logic [31:0] d);
        v[i] = 1'b1; rd[i] = r; dat[i] = d;
    endtask

    initial begin
        out_known = 1'b0;
        m_ptr = 0; m_wr = 1'b0; m_dir = '0; m_di = '0;
        for (int i = 0; i < 3; i++) begin v[i] = 1'b0; rd[i] = '0; dat[i] = '0; end
`ifdef WB_FWD_EN
        rs1_addr = 5'd0; rs2_addr = 5'd0;
`endif

        // reset with all sources requesting
        rst = 1'b1;
        set_src(0, 5'd1, 32'hAAAA0001);
        set_src(1, 5'd2, 32'hBBBB0002);
        set_src(2, 5'd3, 32'hCCCC0003);
        drive_and_check();
        chk("rst_ready", 32'({alu_ready, lsu_ready, mdu_ready}), 32'd0);
        tick();
        drive_and_check();
        chk("rst_reg_wr", 32'(REG_WR), 32'd0);
        chk("rst_dir_wr", 32'(DIR_WR), 32'd0);
        tick();

        // contention rotation ALU, LSU, MDU
        rst = 1'b0;
        drive_and_check();
        chk("first_grant_alu", 32'({alu_ready, lsu_ready, mdu_ready}), 32'b100);
        tick();
        drive_and_check();
        chk("grant_lsu", 32'(lsu_ready), 32'd1);
        chk("dir_1", 32'(DIR_WR), 32'd1);
        tick();
        drive_and_check();
        chk("grant_mdu", 32'(mdu_ready), 32'd1);
        chk("dir_2", 32'(DIR_WR), 32'd2);
        tick();
        drive_and_check();
        chk("dir_3", 32'(DIR_WR), 32'd3);
        chk("di_3", DI, 32'hCCCC0003);
        tick();
        drive_and_check();
        chk("idle_wr", 32'(REG_WR), 32'd0);
        chk("idle_hold", 32'(DIR_WR), 32'd3);
        tick();

        // single write
        set_src(0, 5'd5, 32'hDEADBEEF);
        drive_and_check();
        chk("single_ready", 32'(alu_ready), 32'd1);
        tick();
        drive_and_check();
        chk("single_wr", 32'(REG_WR), 32'd1);
        chk("single_dir", 32'(DIR_WR), 32'd5);
        chk("single_di", DI, 32'hDEADBEEF);
        tick();
        drive_and_check();
        chk("single_done", 32'(REG_WR), 32'd0);

        // x0 write accepted but dropped
        set_src(1, 5'd0, 32'h00001234);
        drive_and_check();
        chk("x0_ready", 32'(lsu_ready), 32'd1);
        tick();
        set_src(0, 5'd4, 32'h4);
        set_src(1, 5'd6, 32'h6);
        set_src(2, 5'd7, 32'h7);
`ifdef WB_FWD_EN
        rs1_addr = 5'd0; rs2_addr = 5'd0;
`endif
        drive_and_check();
        chk("x0_no_wr", 32'(REG_WR), 32'd0);
        chk("x0_ptr_mdu", 32'({alu_ready, lsu_ready, mdu_ready}), 32'b001);
        tick();

`ifdef WB_FWD_EN
        // forwarding hit on rs1 only, MDU write to x7 now on the port
        rs1_addr = 5'd7; rs2_addr = 5'd8;
        drive_and_check();
        chk("fwd_a", 32'(fwd_a_hit), 32'd1);
        chk("fwd_b", 32'(fwd_b_hit), 32'd0);
        chk("fwd_d", fwd_data, 32'h7);
`endif

        // reset while MDU requests, ALU wins afterwards
        set_src(2, 5'd9, 32'h9);
        rst = 1'b1;
        drive_and_check();
        chk("midrst_ready", 32'(mdu_ready), 32'd0);
        tick();
        rst = 1'b0;
        drive_and_check();
        chk("midrst_wr", 32'(REG_WR), 32'd0);
        chk("midrst_alu", 32'({alu_ready, lsu_ready, mdu_ready}), 32'b100);
        tick();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            for (int i = 0; i < 3; i++) begin
                if (!v[i] && $urandom_range(0, 1) == 1) begin
                    set_src(i, ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(0, 31)), $urandom);
                end
            end
`ifdef WB_FWD_EN
            rs1_addr = ($urandom_range(0, 1) == 1) ? m_dir : 5'($urandom_range(0, 31));
            rs2_addr = 5'($urandom_range(0, 31));
`endif
            drive_and_check();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
